// File: rtl/grf_wb_pkg.sv
// Shared constants and types for the W-stage register file slice.
package grf_wb_pkg;

    localparam logic [31:0] ZERO     = 32'h0000_0000;
    localparam logic [31:0] PC_BEGIN = 32'h0000_3000;
    localparam logic [4:0]  REG_ZERO = 5'd0;
    localparam int unsigned NUM_REGS = 32;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rw;
        logic [31:0] data;
    } commit_t;

    // A write only lands when enabled and not aimed at the hardwired zero register.
    function automatic logic reg_write_hit(input logic we, input logic [4:0] rw);
        return we && (rw != REG_ZERO);
    endfunction

endpackage

// File: rtl/grf_wb_array.sv
// 32x32 register storage with synchronous clear and a single write port.
module grf_array
    import grf_wb_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);

    logic [31:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= ZERO;
            end
        end else if (reg_write_hit(we, wa)) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = regs[ra1];
    assign rd2 = regs[ra2];

endmodule

// File: rtl/grf_wb.sv
// Register file with W-stage bypass, commit record and retired-instruction counter.
module grf_wb
    import grf_wb_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_BEGIN,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      IR_W,
    input  logic [31:0]      PC_W,
    input  logic [31:0]      WB_W,
    input  logic [4:0]       RW_W,
    input  logic             RegWr_W,
    input  logic [4:0]       A1,
    input  logic [4:0]       A2,
    output logic [31:0]      RD1,
    output logic [31:0]      RD2,
    output logic             commit_valid,
    output logic [31:0]      commit_pc,
    output logic [31:0]      commit_data,
    output logic [4:0]       commit_rw,
    output logic [CNT_W-1:0] retired_cnt
);

    logic        wr_hit;
    logic [31:0] arr_rd1;
    logic [31:0] arr_rd2;
    commit_t     commit_q;
    logic [CNT_W-1:0] cnt_q;

    assign wr_hit = reg_write_hit(RegWr_W, RW_W);

    grf_array u_array (
        .clk   (clk),
        .reset (reset),
        .we    (RegWr_W),
        .wa    (RW_W),
        .wd    (WB_W),
        .ra1   (A1),
        .ra2   (A2),
        .rd1   (arr_rd1),
        .rd2   (arr_rd2)
    );

    // Bypass stays live during reset so D-stage reads see the in-flight value.
    always_comb begin
        RD1 = arr_rd1;
        RD2 = arr_rd2;
        if (A1 == REG_ZERO) begin
            RD1 = ZERO;
        end else if (wr_hit && (RW_W == A1)) begin
            RD1 = WB_W;
        end
        if (A2 == REG_ZERO) begin
            RD2 = ZERO;
        end else if (wr_hit && (RW_W == A2)) begin
            RD2 = WB_W;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            commit_q.valid <= 1'b0;
            commit_q.pc    <= PC_RESET;
            commit_q.rw    <= REG_ZERO;
            commit_q.data  <= ZERO;
        end else begin
            commit_q.valid <= wr_hit;
            if (wr_hit) begin
                commit_q.pc   <= PC_W;
                commit_q.rw   <= RW_W;
                commit_q.data <= WB_W;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (IR_W != ZERO) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign commit_valid = commit_q.valid;
    assign commit_pc    = commit_q.pc;
    assign commit_rw    = commit_q.rw;
    assign commit_data  = commit_q.data;
    assign retired_cnt  = cnt_q;

endmodule

// File: tb/tb_grf_wb.sv
// Directed self-checking bench for grf_wb; a 4-bit-counter instance exercises wrap.
module tb_grf_wb;

    logic        clk;
    logic        reset;
    logic [31:0] IR_W;
    logic [31:0] PC_W;
    logic [31:0] WB_W;
    logic [4:0]  RW_W;
    logic        RegWr_W;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] RD1, RD2;
    logic        commit_valid;
    logic [31:0] commit_pc, commit_data;
    logic [4:0]  commit_rw;
    logic [31:0] retired_cnt;

    logic [31:0] s_rd1, s_rd2;
    logic        s_commit_valid;
    logic [31:0] s_commit_pc, s_commit_data;
    logic [4:0]  s_commit_rw;
    logic [3:0]  s_retired_cnt;

    int errors = 0;
    int checks = 0;

    grf_wb dut (
        .clk          (clk),
        .reset        (reset),
        .IR_W         (IR_W),
        .PC_W         (PC_W),
        .WB_W         (WB_W),
        .RW_W         (RW_W),
        .RegWr_W      (RegWr_W),
        .A1           (A1),
        .A2           (A2),
        .RD1          (RD1),
        .RD2          (RD2),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .commit_data  (commit_data),
        .commit_rw    (commit_rw),
        .retired_cnt  (retired_cnt)
    );

    grf_wb #(.CNT_W(4)) dut_small (
        .clk          (clk),
        .reset        (reset),
        .IR_W         (IR_W),
        .PC_W         (PC_W),
        .WB_W         (WB_W),
        .RW_W         (RW_W),
        .RegWr_W      (RegWr_W),
        .A1           (A1),
        .A2           (A2),
        .RD1          (s_rd1),
        .RD2          (s_rd2),
        .commit_valid (s_commit_valid),
        .commit_pc    (s_commit_pc),
        .commit_data  (s_commit_data),
        .commit_rw    (s_commit_rw),
        .retired_cnt  (s_retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; IR_W = '0; PC_W = '0; WB_W = '0; RW_W = '0;
        RegWr_W = 1'b0; A1 = 5'd5; A2 = 5'd31;
        tick();
        reset = 1'b0;
        #1;
        checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0h exp=0", commit_valid); end
        checks++; if (commit_pc !== 32'h0000_3000) begin errors++; $display("FAIL rst_pc got=%08h exp=00003000", commit_pc); end
        checks++; if (commit_rw !== 5'd0) begin errors++; $display("FAIL rst_rw got=%0d exp=0", commit_rw); end
        checks++; if (commit_data !== 32'h0) begin errors++; $display("FAIL rst_data got=%08h exp=0", commit_data); end
        checks++; if (retired_cnt !== 32'h0) begin errors++; $display("FAIL rst_cnt got=%0d exp=0", retired_cnt); end
        checks++; if (RD1 !== 32'h0 || RD2 !== 32'h0) begin errors++; $display("FAIL rst_rd got=%08h/%08h exp=0/0", RD1, RD2); end
    endtask

    task automatic test_bypass();
        RegWr_W = 1'b1; RW_W = 5'd5; WB_W = 32'hDEAD_BEEF; PC_W = 32'h0000_3004; A1 = 5'd5; A2 = 5'd6;
        #1;
        checks++; if (RD1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_rd1 got=%08h exp=deadbeef", RD1); end
        checks++; if (RD2 !== 32'h0) begin errors++; $display("FAIL bypass_rd2_other got=%08h exp=0", RD2); end
        tick();
        RegWr_W = 1'b0;
        #1;
        checks++; if (RD1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL stored_rd1 got=%08h exp=deadbeef", RD1); end
        checks++; if (commit_valid !== 1'b1 || commit_rw !== 5'd5) begin errors++; $display("FAIL commit5 got=%0h/%0d exp=1/5", commit_valid, commit_rw); end
        checks++; if (commit_pc !== 32'h0000_3004 || commit_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL commit5_pd got=%08h/%08h exp=00003004/deadbeef", commit_pc, commit_data); end
        // Independent per-port bypass: A2 hits the write, A1 reads storage.
        RegWr_W = 1'b1; RW_W = 5'd9; WB_W = 32'h0000_00AA; A1 = 5'd5; A2 = 5'd9;
        #1;
        checks++; if (RD1 !== 32'hDEAD_BEEF || RD2 !== 32'h0000_00AA) begin errors++; $display("FAIL split_bypass got=%08h/%08h exp=deadbeef/000000aa", RD1, RD2); end
        tick();
        RegWr_W = 1'b0;
    endtask

    task automatic test_rw_zero();
        RegWr_W = 1'b0; tick();
        RegWr_W = 1'b1; RW_W = 5'd0; WB_W = 32'h1234_5678; PC_W = 32'h0000_3100; A1 = 5'd0; A2 = 5'd0;
        #1;
        checks++; if (RD1 !== 32'h0 || RD2 !== 32'h0) begin errors++; $display("FAIL zero_rd got=%08h/%08h exp=0/0", RD1, RD2); end
        tick();
        RegWr_W = 1'b0;
        #1;
        checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL zero_valid got=%0h exp=0", commit_valid); end
        checks++; if (commit_pc !== 32'h0000_3004 || commit_rw !== 5'd9 || commit_data !== 32'h0000_00AA)
            begin errors++; $display("FAIL zero_hold got=%08h/%0d/%08h exp=00003004/9/000000aa", commit_pc, commit_rw, commit_data); end
    endtask

    task automatic test_counter();
        RegWr_W = 1'b0;
        for (int i = 0; i < 10; i++) begin
            IR_W = (i % 2 == 0) ? 32'h2408_0001 : 32'h0;
            tick();
        end
        IR_W = '0;
        #1;
        checks++; if (retired_cnt !== 32'd5) begin errors++; $display("FAIL cnt_alt got=%0d exp=5", retired_cnt); end
        checks++; if (s_retired_cnt !== 4'd5) begin errors++; $display("FAIL cnt_small got=%0d exp=5", s_retired_cnt); end
        IR_W = 32'h2408_0001;
        for (int i = 0; i < 10; i++) tick();
        IR_W = '0;
        #1;
        checks++; if (s_retired_cnt !== 4'hF) begin errors++; $display("FAIL cnt_allones got=%0d exp=15", s_retired_cnt); end
        IR_W = 32'h2408_0001;
        tick();
        IR_W = '0;
        #1;
        checks++; if (s_retired_cnt !== 4'h0) begin errors++; $display("FAIL cnt_wrap got=%0d exp=0", s_retired_cnt); end
        checks++; if (retired_cnt !== 32'd16) begin errors++; $display("FAIL cnt_wide got=%0d exp=16", retired_cnt); end
        // Write enable is authoritative even for a bubble; counter stays put.
        RegWr_W = 1'b1; RW_W = 5'd10; WB_W = 32'hCAFE_0010; A1 = 5'd10;
        tick();
        RegWr_W = 1'b0;
        #1;
        checks++; if (RD1 !== 32'hCAFE_0010 || retired_cnt !== 32'd16)
            begin errors++; $display("FAIL bubble_write got=%08h/%0d exp=cafe0010/16", RD1, retired_cnt); end
    endtask

    task automatic test_reset_priority();
        RegWr_W = 1'b1; RW_W = 5'd7; WB_W = 32'h0000_0077; PC_W = 32'h0000_3200;
        tick();
        reset = 1'b1; RegWr_W = 1'b1; RW_W = 5'd7; WB_W = 32'h0000_0055; IR_W = 32'h2408_0001; A1 = 5'd7; A2 = 5'd10;
        #1;
        checks++; if (RD1 !== 32'h0000_0055 || RD2 !== 32'hCAFE_0010)
            begin errors++; $display("FAIL rst_bypass got=%08h/%08h exp=00000055/cafe0010", RD1, RD2); end
        tick();
        reset = 1'b0; RegWr_W = 1'b0; IR_W = '0;
        #1;
        checks++; if (RD1 !== 32'h0 || RD2 !== 32'h0) begin errors++; $display("FAIL rst_clear got=%08h/%08h exp=0/0", RD1, RD2); end
        checks++; if (commit_pc !== 32'h0000_3000 || commit_valid !== 1'b0)
            begin errors++; $display("FAIL rst_prio_commit got=%08h/%0h exp=00003000/0", commit_pc, commit_valid); end
        checks++; if (retired_cnt !== 32'd0 || s_retired_cnt !== 4'd0)
            begin errors++; $display("FAIL rst_prio_cnt got=%0d/%0d exp=0/0", retired_cnt, s_retired_cnt); end
        RegWr_W = 1'b1; RW_W = 5'd7; WB_W = 32'h0000_0099; PC_W = 32'h0000_3300; IR_W = 32'h2408_0001;
        tick();
        RegWr_W = 1'b0; IR_W = '0;
        #1;
        checks++; if (RD1 !== 32'h0000_0099 || commit_valid !== 1'b1 || retired_cnt !== 32'd1)
            begin errors++; $display("FAIL post_rst got=%08h/%0h/%0d exp=00000099/1/1", RD1, commit_valid, retired_cnt); end
    endtask

    task automatic test_back_to_back();
        RegWr_W = 1'b1; RW_W = 5'd3; WB_W = 32'h1; PC_W = 32'h0000_3400; A1 = 5'd3; A2 = 5'd3;
        #1;
        checks++; if (RD1 !== 32'h1 || RD2 !== 32'h1) begin errors++; $display("FAIL b2b_first got=%08h/%08h exp=1/1", RD1, RD2); end
        tick();
        WB_W = 32'h2; PC_W = 32'h0000_3404;
        #1;
        checks++; if (RD1 !== 32'h2 || RD2 !== 32'h2) begin errors++; $display("FAIL b2b_second got=%08h/%08h exp=2/2", RD1, RD2); end
        checks++; if (commit_data !== 32'h1 || commit_pc !== 32'h0000_3400)
            begin errors++; $display("FAIL b2b_commit1 got=%08h/%08h exp=1/00003400", commit_data, commit_pc); end
        tick();
        RegWr_W = 1'b0;
        #1;
        checks++; if (RD1 !== 32'h2 || RD2 !== 32'h2) begin errors++; $display("FAIL b2b_stored got=%08h/%08h exp=2/2", RD1, RD2); end
        checks++; if (commit_data !== 32'h2 || commit_rw !== 5'd3)
            begin errors++; $display("FAIL b2b_commit2 got=%08h/%0d exp=2/3", commit_data, commit_rw); end
        tick();
        #1;
        checks++; if (commit_valid !== 1'b0 || commit_data !== 32'h2)
            begin errors++; $display("FAIL b2b_idle got=%0h/%08h exp=0/2", commit_valid, commit_data); end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_rw_zero();
        test_counter();
        test_reset_priority();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
